id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register of the MIPS32 pipeline. Consumes the 8x32 register-file read data and decode controls.
//  Resolves RAW hazards by forwarding (or stalling) and drives stall/bubble handshakes to IF/ID.
//  Latches operands and controls for the EX stage; sits between decode/register file and the ALU.
// PARAMETERS
//  DATA_W    32  operand/result width
//  REG_AW    3   register index width (8 registers; index 0 is an ordinary writable register, no hardwired zero)
//  ALU_OP_W  4   ALU operation code width
//  CNT_W     16  stall performance counter width
// PORTS
//  clk            in   1         clock, all state updates on posedge
//  rst_n          in   1         synchronous, active-low reset
//  id_valid       in   1         decode slot holds a valid instruction
//  id_rs, id_rt   in   REG_AW    source indices (also drive register-file read addresses)
//  id_use_rs/rt   in   1         instruction actually reads rs / rt
//  id_dst         in   REG_AW    destination index
//  id_reg_write   in   1         instruction writes the register file
//  id_mem_read    in   1         instruction is a load
//  id_mem_write   in   1         instruction is a store
//  id_alu_op      in   ALU_OP_W  ALU operation
//  id_alu_src     in   1         1 = operand B is immediate
//  id_imm         in   DATA_W    sign-extended immediate
//  rf_data_1/2    in   DATA_W    register-file read data for rs / rt (combinational read)
//  flush          in   1         branch squash from EX
//  ex_result      in   DATA_W    ALU result of instruction now in EX (this block's outputs)
//  mem_reg_write  in   1         MEM-stage instruction writes
//  mem_dst        in   REG_AW    MEM-stage destination
//  mem_data       in   DATA_W    MEM-stage final value (load data or ALU result)
//  wb_reg_write   in   1         WB-stage write enable (same signal as register-file write enable)
//  wb_dst         in   REG_AW    WB destination
//  wb_data        in   DATA_W    WB write data
//  stall          out  1         hold PC and IF/ID this cycle
//  ex_valid       out  1         EX slot valid
//  ex_op_a/op_b   out  DATA_W    resolved operand A / B (B = imm when alu_src)
//  ex_store_data  out  DATA_W    resolved rt value for stores
//  ex_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op  out  controls
//  stall_count    out  CNT_W     cycles with stall=1, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, stall_count 0; a bubble is valid=0 with all write/mem controls 0.
//  - Latency 1 cycle: inputs sampled at posedge appear on ex_* next cycle.
//  - Hazard match: valid producer, its reg_write=1, dst == used source (rs with use_rs, rt with use_rt).
//  - WB match always bypasses: register-file write lands at the same posedge, so RF data read this cycle is stale.
//  - Priority per operand: EX > MEM > WB > rf_data.
//  - stall=1: ID/EX loads a bubble; decode inputs are held by upstream and re-sampled next cycle.
//  - flush=1: ID/EX loads a bubble and stall forced 0. Flush beats stall; no stall_count increment.
//  - stall and ex_* depend only on current inputs and registered EX state; no combinational loop through stall.
//  - id_valid=0: no stall, bubble loaded.
//  - stall_count increments on every cycle stall=1 and holds at all-ones.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - EX (ex_result, not a load), MEM and WB matches are forwarded.
//   - Stall only on load-use: EX slot valid, mem_read=1 and matching; exactly 1 bubble, then forwarded from MEM.
//  FORWARDING_EN undefined:
//   - No EX/MEM forwarding; stall while any EX or MEM match exists.
//   - WB-to-ID bypass is kept (required for correctness).
//   - A dependent instruction right behind its producer stalls 2 cycles.
// STRUCTURE
//  - Shared package pipeline_pkg: ALU op localparams, REG_AW/DATA_W constants, control-bundle width/field offsets.
//  - Sub-module fwd_mux: one instance per operand; inputs are source index, use bit and the three producers;
//    outputs are selected data and a hazard flag.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with traffic -> all outputs 0, stall_count 0.
//  - add r1 then add r2,r1 (ex_result=0x10) -> FWD_EN: op_a=0x10, no stall; no FWD_EN: 2 stall cycles, then op_a=wb_data.
//  - lw r3 then add r4,r3 -> exactly 1 bubble (ex_valid=0); next cycle op_a=mem_data=0xDEADBEEF; stall_count=1.
//  - rf_data_1=0, wb_reg_write=1, wb_dst=rs, wb_data=0x55 -> op_a=0x55.
//  - EX and MEM both write r5 (0xA / 0xB) -> op_a=0xA (EX wins).
//  - flush with load-use hazard pending -> stall=0, bubble latched, stall_count unchanged.
//  - Force 2^16+3 stall cycles -> stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared constants for the MIPS32 pipeline slice: operand/register widths,
// ALU operation codes, the packed layout of the ID->EX control bundle and
// the operand-source select used by the forwarding muxes.
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 3;
    localparam int ALU_OP_W = 4;
    localparam int CNT_W    = 16;

    // ALU operation codes carried on id_alu_op / ex_alu_op
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;

    // Control bundle layout: {mem_write, mem_read, reg_write, dst, alu_op}
    localparam int CTRL_ALU_OP_LSB     = 0;
    localparam int CTRL_DST_LSB        = CTRL_ALU_OP_LSB + ALU_OP_W;
    localparam int CTRL_REG_WRITE_BIT  = CTRL_DST_LSB + REG_AW;
    localparam int CTRL_MEM_READ_BIT   = CTRL_REG_WRITE_BIT + 1;
    localparam int CTRL_MEM_WRITE_BIT  = CTRL_MEM_READ_BIT + 1;
    localparam int CTRL_W              = CTRL_MEM_WRITE_BIT + 1;

    // Where a resolved operand comes from, highest priority last
    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_WB  = 2'd1,
        SRC_MEM = 2'd2,
        SRC_EX  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Per-operand hazard detection and bypass selection for the ID stage.
// Build option: FORWARDING_EN (defined = EX/MEM/WB forwarding with load-use
// stall only; undefined = WB bypass only, stall on any EX/MEM dependence).
// Ports:
//   src, use_src                   source register index and "is read" bit
//   ex_valid/reg_write/mem_read    EX-slot producer state (registered ID/EX)
//   ex_dst, ex_data                EX producer destination and ALU result
//   mem_reg_write/dst/data         MEM-stage producer
//   wb_reg_write/dst/data          WB-stage producer (same cycle RF write)
//   rf_data                        register-file read data for src
//   fwd_data                       resolved operand value
//   hazard                         operand cannot be resolved this cycle
// ---------------------------------------------------------------------------
module fwd_mux
    import pipeline_pkg::*;
#(
    parameter int DW = pipeline_pkg::DATA_W,
    parameter int AW = pipeline_pkg::REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic          ex_valid,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] ex_dst,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_dst,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    input  logic [DW-1:0] rf_data,
    output logic [DW-1:0] fwd_data,
    output logic          hazard
);

    logic     ex_match;
    logic     mem_match;
    logic     wb_match;
    fwd_src_e sel;

    // Register 0 is an ordinary register, so no zero-index exclusion here.
    assign ex_match  = use_src && ex_valid && ex_reg_write && (ex_dst == src);
    assign mem_match = use_src && mem_reg_write && (mem_dst == src);
    assign wb_match  = use_src && wb_reg_write && (wb_dst == src);

    // Youngest producer wins. A load in EX has no data yet, so it never
    // selects EX; the hazard output turns that case into a stall. Without
    // forwarding the same mux is used, but any EX/MEM match stalls and the
    // selected value is then discarded in favour of a bubble.
    always_comb begin
        sel = SRC_RF;
        if (ex_match && !ex_mem_read) begin
            sel = SRC_EX;
        end else if (mem_match) begin
            sel = SRC_MEM;
        end else if (wb_match) begin
            sel = SRC_WB;
        end
    end

    always_comb begin
        fwd_data = rf_data;
        case (sel)
            SRC_EX:  fwd_data = ex_data;
            SRC_MEM: fwd_data = mem_data;
            SRC_WB:  fwd_data = wb_data;
            default: fwd_data = rf_data;
        endcase
    end

`ifdef FORWARDING_EN
    assign hazard = ex_match && ex_mem_read;
`else
    assign hazard = ex_match || mem_match;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register of the MIPS32 pipeline. Resolves RAW hazards by
// forwarding or stalling, drives the stall handshake to IF/ID and latches
// operands and controls for EX. Build option: FORWARDING_EN (see fwd_mux).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_*                       decoded instruction in the ID slot
//   rf_data_1/2                register-file read data for rs / rt
//   flush                      branch squash from EX (beats stall)
//   ex_result                  ALU result of the instruction now in EX
//   mem_*/wb_*                 downstream producers for forwarding
//   stall                      hold PC and IF/ID this cycle
//   ex_*                       registered operands/controls for EX
//   stall_count                saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int REG_AW   = pipeline_pkg::REG_AW,
    parameter int ALU_OP_W = pipeline_pkg::ALU_OP_W,
    parameter int CNT_W    = pipeline_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_AW-1:0]   id_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [DATA_W-1:0]   rf_data_1,
    input  logic [DATA_W-1:0]   rf_data_2,
    input  logic                flush,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic                mem_reg_write,
    input  logic [REG_AW-1:0]   mem_dst,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_dst,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_op_a,
    output logic [DATA_W-1:0]   ex_op_b,
    output logic [DATA_W-1:0]   ex_store_data,
    output logic [REG_AW-1:0]   ex_dst,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [CNT_W-1:0]    stall_count
);

    import pipeline_pkg::*;

    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              haz_a;
    logic              haz_b;
    logic              take;
    logic [CTRL_W-1:0] id_ctrl;
    logic [CTRL_W-1:0] ex_ctrl;

    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_a (
        .src           (id_rs),
        .use_src       (id_use_rs),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dst        (ex_dst),
        .ex_data       (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .rf_data       (rf_data_1),
        .fwd_data      (val_a),
        .hazard        (haz_a)
    );

    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_b (
        .src           (id_rt),
        .use_src       (id_use_rt),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dst        (ex_dst),
        .ex_data       (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .rf_data       (rf_data_2),
        .fwd_data      (val_b),
        .hazard        (haz_b)
    );

    // Stall depends only on ID inputs and registered EX state (never on
    // ex_result), so there is no combinational path from stall back to itself.
    assign stall = id_valid && !flush && (haz_a || haz_b);
    assign take  = id_valid && !flush && !stall;

    assign id_ctrl = {id_mem_write, id_mem_read, id_reg_write, id_dst, id_alu_op};

    // Either the decoded instruction or a bubble enters EX; a bubble clears
    // every field so nothing downstream can write or touch memory.
    always_ff @(posedge clk) begin
        if (!rst_n || !take) begin
            ex_valid      <= 1'b0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_ctrl       <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_op_a       <= val_a;
            ex_op_b       <= id_alu_src ? id_imm : val_b;
            ex_store_data <= val_b;
            ex_ctrl       <= id_ctrl;
        end
    end

    assign ex_alu_op    = ex_ctrl[CTRL_ALU_OP_LSB +: ALU_OP_W];
    assign ex_dst       = ex_ctrl[CTRL_DST_LSB +: REG_AW];
    assign ex_reg_write = ex_ctrl[CTRL_REG_WRITE_BIT];
    assign ex_mem_read  = ex_ctrl[CTRL_MEM_READ_BIT];
    assign ex_mem_write = ex_ctrl[CTRL_MEM_WRITE_BIT];

    // Saturating stall counter; holds at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
